// File: rtl/wb_queue_if.sv
// Bundle of the memory-stage input handshake, register-file write port,
// forwarding view and retire counter used by the write-back queue.
interface wb_queue_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    localparam int LANE_W = $clog2(XLEN / 8);

    // Memory stage -> write-back
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd_i;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   load_raw;
    logic [LANE_W-1:0] addr_lo;

    // Write-back -> register file
    logic              wr_ready;
    logic              wr_en;
    logic [4:0]        rd_o;
    logic [XLEN-1:0]   rd_data;

    // Bypass view of the queue head and retire count
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic [CNT_W-1:0]  retire_cnt;

    // View of the write-back queue itself
    modport slave (
        input  in_valid, opcode, funct3, rd_i, alu_out, load_raw, addr_lo, wr_ready,
        output in_ready, wr_en, rd_o, rd_data, fwd_valid, fwd_rd, fwd_data, retire_cnt
    );

    // View of whoever drives the queue (memory stage / register file side)
    modport master (
        output in_valid, opcode, funct3, rd_i, alu_out, load_raw, addr_lo, wr_ready,
        input  in_ready, wr_en, rd_o, rd_data, fwd_valid, fwd_rd, fwd_data, retire_cnt
    );
endinterface

// File: rtl/wb_queue.sv
// Registered write-back stage: resolves load extraction and the register
// write-enable at enqueue, buffers {we, rd, data} in a DEPTH-entry FIFO,
// drains the head into the register-file port and counts retirements.
module wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    wb_queue_if.slave   bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int LANE_W = $clog2(XLEN / 8);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Only result-producing opcodes write, and never to x0.
    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        logic producer;
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: producer = 1'b1;
            default:                                                 producer = 1'b0;
        endcase
        return producer && (rd != 5'd0);
    endfunction

    // Lane selection ignores address bits below the access size; the size
    // casts of signed values perform the sign extension.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]        f3,
                                                     input logic [XLEN-1:0]   raw,
                                                     input logic [LANE_W-1:0] lane);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] r;
        b = raw[8 * int'(lane) +: 8];
        h = raw[16 * (int'(lane) / 2) +: 16];
        w = raw[32 * (int'(lane) / 4) +: 32];
        r = '0;
        case (f3)
            3'b000: r = XLEN'($signed(b));
            3'b001: r = XLEN'($signed(h));
            3'b010: r = XLEN'($signed(w));
            3'b100: r = XLEN'(b);
            3'b101: r = XLEN'(h);
            3'b110: if (XLEN == 64) r = XLEN'(w);
            3'b011: if (XLEN == 64) r = raw;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic             we_q   [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic             in_ready;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             head_wr;
    logic             entry_we;
    logic [XLEN-1:0]  entry_data;

    // Enqueue resolution, drain decision and next-state for pointers/counters.
    always_comb begin
        in_ready   = (count_q < OCC_W'(DEPTH));
        push       = bus.in_valid && in_ready;
        head_valid = (count_q != '0);
        head_wr    = head_valid && we_q[rd_ptr_q];
        // Non-writing heads retire without waiting for the register file.
        pop        = head_valid && (!we_q[rd_ptr_q] || bus.wr_ready);

        entry_we   = writes_rd(bus.opcode, bus.rd_i);
        entry_data = (bus.opcode == OP_LOAD) ?
                     load_extract(bus.funct3, bus.load_raw, bus.addr_lo) : bus.alu_out;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        retire_d = retire_q + CNT_W'(pop);
    end

    // Pointer, occupancy and retire-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            retire_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            retire_q <= retire_d;
        end
    end

    // FIFO storage; reset clears every entry so nothing stale can be forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                we_q[i]   <= 1'b0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            we_q[wr_ptr_q]   <= entry_we;
            rd_q[wr_ptr_q]   <= bus.rd_i;
            data_q[wr_ptr_q] <= entry_data;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = head_wr;
    assign bus.rd_o       = head_wr ? rd_q[rd_ptr_q]   : '0;
    assign bus.rd_data    = head_wr ? data_q[rd_ptr_q] : '0;
    assign bus.fwd_valid  = head_wr;
    assign bus.fwd_rd     = head_wr ? rd_q[rd_ptr_q]   : '0;
    assign bus.fwd_data   = head_wr ? data_q[rd_ptr_q] : '0;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue (XLEN=32, DEPTH=2, CNT_W=4): directed cases plus a
// randomized run, all compared against a queue-based reference model.
module tb_wb_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_queue_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t             mq[$];
    logic [CNT_W-1:0] mcnt;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_we(input logic [6:0] op, input logic [4:0] rd);
        return (op inside {OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) && (rd != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] raw, input int lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * lo)) & 32'hFF;
        h = (raw >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2:    return raw;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] raw,
                        input logic [1:0] lo, input logic wrr);
        logic        exp_wr;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        mpush;
        logic        mpop;
        ent_t        e;
        ent_t        tmp;
        bus.in_valid = v;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.rd_i     = rd;
        bus.alu_out  = alu;
        bus.load_raw = raw;
        bus.addr_lo  = lo;
        bus.wr_ready = wrr;
        #2;
        exp_wr   = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
        if (mq.size() > 0) begin
            if (mq[0].we) begin
                exp_wr   = 1'b1;
                exp_rd   = mq[0].rd;
                exp_data = mq[0].data;
            end
        end
        check_val("in_ready",   bus.in_ready,   64'(mq.size() < DEPTH));
        check_val("wr_en",      bus.wr_en,      64'(exp_wr));
        check_val("rd_o",       bus.rd_o,       64'(exp_rd));
        check_val("rd_data",    bus.rd_data,    64'(exp_data));
        check_val("fwd_valid",  bus.fwd_valid,  64'(exp_wr));
        check_val("fwd_rd",     bus.fwd_rd,     64'(exp_rd));
        check_val("fwd_data",   bus.fwd_data,   64'(exp_data));
        check_val("retire_cnt", bus.retire_cnt, 64'(mcnt));
        mpush   = v && (mq.size() < DEPTH);
        mpop    = (mq.size() > 0) && (!exp_wr || wrr);
        e.we    = m_we(op, rd);
        e.rd    = rd;
        e.data  = (op == OP_LOAD) ? m_load(f3, raw, int'(lo)) : alu;
        @(posedge clk);
        if (mpop) begin
            tmp  = mq.pop_front();
            mcnt = mcnt + 1'b1;
        end
        if (mpush) mq.push_back(e);
        #1;
    endtask

    task automatic idle(input logic wrr);
        step(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, wrr);
    endtask

    task automatic add(input logic [4:0] rd, input logic [31:0] alu, input logic wrr);
        step(1'b1, OP_R, 3'd0, rd, alu, 32'd0, 2'd0, wrr);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        check_val("rst_wr_en",     bus.wr_en,      64'd0);
        check_val("rst_rd_o",      bus.rd_o,       64'd0);
        check_val("rst_rd_data",   bus.rd_data,    64'd0);
        check_val("rst_fwd_valid", bus.fwd_valid,  64'd0);
        check_val("rst_fwd_rd",    bus.fwd_rd,     64'd0);
        check_val("rst_fwd_data",  bus.fwd_data,   64'd0);
        check_val("rst_retire",    bus.retire_cnt, 64'd0);
        check_val("rst_in_ready",  bus.in_ready,   64'd1);
        mq.delete();
        mcnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [6:0]  ops   [9] = '{OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_STORE, OP_BR};
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd7};
    logic [1:0]  ld_lo [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_ex [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F81, 32'h0};

    initial begin
        mcnt = '0;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.funct3   = '0;
        bus.rd_i     = '0;
        bus.alu_out  = '0;
        bus.load_raw = '0;
        bus.addr_lo  = '0;
        bus.wr_ready = 1'b0;
        #1;
        check_val("init_wr_en",    bus.wr_en,     64'd0);
        check_val("init_in_ready", bus.in_ready,  64'd1);
        check_val("init_fwd",      bus.fwd_valid, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic ALU write-back, one-cycle latency, retire counted on pop
        add(5'd5, 32'h0000_1234, 1'b1);
        check_val("add_wr_en",   bus.wr_en,   64'd1);
        check_val("add_rd_o",    bus.rd_o,    64'd5);
        check_val("add_rd_data", bus.rd_data, 64'h1234);
        idle(1'b1);
        check_val("add_retire",  bus.retire_cnt, 64'd1);

        // Load extraction from a fixed memory word
        for (int i = 0; i < 5; i++) begin
            step(1'b1, OP_LOAD, ld_f3[i], 5'd7, 32'hDEAD_BEEF, 32'h80F0_7F81, ld_lo[i], 1'b1);
            check_val("load_data", bus.rd_data, 64'(ld_ex[i]));
            idle(1'b1);
        end

        // Store and write to x0 retire without writing
        do_reset();
        step(1'b1, OP_STORE, 3'd2, 5'd3, 32'h55, 32'd0, 2'd0, 1'b0);
        check_val("sw_fwd", bus.fwd_valid, 64'd0);
        step(1'b1, OP_IMM, 3'd0, 5'd0, 32'h77, 32'd0, 2'd0, 1'b0);
        check_val("x0_wr_en", bus.wr_en, 64'd0);
        idle(1'b0);
        idle(1'b0);
        check_val("nowr_retire", bus.retire_cnt, 64'd2);

        // Backpressure: full queue holds the third instruction
        do_reset();
        add(5'd1, 32'h11, 1'b0);
        add(5'd2, 32'h22, 1'b0);
        check_val("bp_full", bus.in_ready, 64'd0);
        add(5'd3, 32'h33, 1'b0);
        check_val("bp_hold_rd", bus.rd_o, 64'd1);
        add(5'd3, 32'h33, 1'b1);
        check_val("bp_rd2",    bus.rd_o,     64'd2);
        check_val("bp_ready",  bus.in_ready, 64'd1);
        add(5'd3, 32'h33, 1'b1);
        check_val("bp_rd3",    bus.rd_o,    64'd3);
        check_val("bp_data3",  bus.rd_data, 64'h33);
        idle(1'b1);
        check_val("bp_empty",  bus.wr_en,      64'd0);
        check_val("bp_retire", bus.retire_cnt, 64'd3);

        // Reset with two queued entries discards them
        do_reset();
        add(5'd4, 32'h44, 1'b0);
        add(5'd6, 32'h66, 1'b0);
        do_reset();
        idle(1'b1);
        idle(1'b1);
        check_val("rst_no_write", bus.wr_en, 64'd0);

        // Retire counter wraps modulo 2^CNT_W
        do_reset();
        for (int i = 0; i < 17; i++) add(5'd1, 32'(i), 1'b1);
        idle(1'b1);
        check_val("retire_wrap", bus.retire_cnt, 64'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 8)],
                 3'($urandom_range(0, 7)), rd, $urandom, $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
# wb_queue

Parametrised, registered write-back stage for the RISC-V core. It accepts completed instructions from the memory stage over a valid/ready handshake and performs load byte/halfword selection and sign/zero extension. Results are buffered in a DEPTH-entry FIFO and drained into the register-file write port under a write-ready handshake. It also exposes the queue head for forwarding and maintains a retired-instruction counter.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- CNT_W, 64: retire counter width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  memory stage presents an instruction.
- in_ready  output  1  stage can accept; high when occupancy < DEPTH.
- opcode  input  7  instruction opcode (shared opcode definitions).
- funct3  input  3  instruction funct3.
- rd_i  input  5  destination register.
- alu_out  input  XLEN  ALU/link/immediate result.
- load_raw  input  XLEN  naturally aligned memory word.
- addr_lo  input  $clog2(XLEN/8)  low effective-address bits.
- wr_ready  input  1  register-file port accepts a write this cycle.
- wr_en  output  1  write request to the register file.
- rd_o  output  5  write address.
- rd_data  output  XLEN  write data.
- fwd_valid, fwd_rd, fwd_data  output  1/5/XLEN  head entry, when it is a pending write, for bypass.
- retire_cnt  output  CNT_W  count of retired instructions.

## Operation
- Enqueue when in_valid && in_ready. Data is resolved at enqueue; the FIFO stores {we, rd, data}.
- we = 1 for opcodes R (0110011), I-arith (0010011), load (0000011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111), and only when rd_i ≠ 0. Otherwise we = 0.
- Data is alu_out unless opcode is load.
- Load data, where lane = addr_lo:
  - LB 000: byte[lane], sign-extended.
  - LH 001: half[lane>>1], sign-extended.
  - LW 010: word[lane>>2]. Sign-extended when XLEN = 64.
  - LBU 100, LHU 101: as LB/LH but zero-extended.
  - LWU 110, LD 011: XLEN = 64 only.
  - Any other funct3: data = 0.
  - Lane bits below the access size are ignored; there is no misalignment trap.
- Drain from the head only:
  - Head we = 1: wr_en = 1, rd_o and rd_data come from the head. The entry pops when wr_ready = 1.
  - Head we = 0: wr_en = 0 and the entry pops unconditionally.
  - Queue empty: wr_en = 0, rd_o = 0, rd_data = 0.
- fwd_valid = head valid && head we. fwd_rd and fwd_data mirror the head, and are 0 when fwd_valid = 0.
- retire_cnt increments by 1 on every pop and wraps modulo 2^CNT_W.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap at DEPTH. Occupancy is $clog2(DEPTH)+1 bits.
- Simultaneous push and pop leaves occupancy unchanged.
- in_ready depends only on registered occupancy. There is no combinational path from wr_ready, so a full queue does not accept in the same cycle it pops.

## Timing
- Reset (asynchronous, immediate): pointers and occupancy = 0, retire_cnt = 0, all FIFO entries cleared.
  - Resulting outputs: wr_en = 0, rd_o = 0, rd_data = 0, fwd_* = 0, in_ready = 1.
- Reset mid-operation discards all queued entries without writing them. No register-file write occurs in the reset cycle.
- Latency: an entry enqueued at edge N is presented on wr_en/rd_o/rd_data after edge N, i.e. one cycle later, provided the queue was empty.
- Throughput: 1 instruction per cycle when wr_ready is held high.
- wr_en, rd_o, rd_data and fwd_* are functions of registered state only.
- wr_en holds, and head contents stay stable, until wr_ready is sampled high.

## Test plan
- Reset, then `ADD x5`, alu_out = 0x0000_1234, wr_ready = 1 → next cycle wr_en = 1, rd_o = 5, rd_data = 0x1234; one cycle later retire_cnt = 1.
- Loads with load_raw = 0x80F0_7F81:
  - LB, addr_lo = 0 → 0xFFFF_FF81.
  - LBU, addr_lo = 3 → 0x0000_0080.
  - LH, addr_lo = 2 → 0xFFFF_80F0.
  - LHU, addr_lo = 0 → 0x0000_7F81.
  - funct3 = 111 → 0.
- Non-writing and x0 cases: SW (0100011) and ADDI with rd = 0 → wr_en never asserts; both retire, retire_cnt = 2; fwd_valid stays 0.
- Backpressure: wr_ready = 0, push 3 ADDs (DEPTH = 2) → in_ready = 0 after 2 accepts, third held. Then wr_ready = 1 → writes appear in order; third accepted the cycle after the first pop.
- Async reset asserted between edges with 2 entries queued → outputs go to 0 immediately; after release in_ready = 1, no write of the old entries.
- retire_cnt wrap: CNT_W = 4, retire 17 instructions → retire_cnt = 1.
